commit_buffer: RTL and testbench

//  Parametrised N-lane commit stage between MEM and the regfile/HI-LO write port. Replaces the

---
 rtl/commit_buffer_pkg.sv | 18 +
 rtl/commit_fifo.sv | 71 +++++++
 rtl/commit_buffer.sv | 115 +++++++++++
 tb/tb_commit_buffer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_buffer_pkg.sv
// Shared widths and constants for the commit stage, plus the packed bundle width helper.
package commit_buffer_pkg;

    localparam int REG_BUS_W   = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int INST_ADDR_W = 32;

    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR  = '0;
    localparam logic [REG_BUS_W-1:0]  ZERO_WORD     = '0;
    localparam logic                  WRITE_ENABLE  = 1'b1;
    localparam logic                  WRITE_DISABLE = 1'b0;

    // pc + per lane {vld, waddr, we, wdata} + {hi, lo, whilo}
    function automatic int commit_bundle_w(input int lanes);
        return INST_ADDR_W + lanes * (1 + REG_ADDR_W + 1 + REG_BUS_W) + 2 * REG_BUS_W + 1;
    endfunction

endpackage

// File: rtl/commit_fifo.sv
// Generic DEPTH x WIDTH FIFO with head-entry (zero-latency) read and a synchronous clear.
module commit_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/commit_buffer.sv
// N-lane commit stage: sanitises write enables on entry, buffers bundles, counts retirements.
module commit_buffer
    import commit_buffer_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           pc_i,
    input  logic [LANES-1:0]      lane_vld_i,
    input  logic [5*LANES-1:0]    waddr_i,
    input  logic [LANES-1:0]      we_i,
    input  logic [32*LANES-1:0]   wdata_i,
    input  logic [31:0]           hi_i,
    input  logic [31:0]           lo_i,
    input  logic                  whilo_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           pc_o,
    output logic [5*LANES-1:0]    waddr_o,
    output logic [LANES-1:0]      we_o,
    output logic [32*LANES-1:0]   wdata_o,
    output logic [31:0]           hi_o,
    output logic [31:0]           lo_o,
    output logic                  whilo_o,
    output logic [CNT_W-1:0]      retire_cnt_o
);

    localparam int BW = commit_bundle_w(LANES);

    logic [LANES-1:0]    lane_wr;
    logic [LANES-1:0]    we_san;
    logic [32*LANES-1:0] wdata_san;
    logic [BW-1:0]       wr_bundle;
    logic [BW-1:0]       rd_bundle;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic [LANES-1:0]    head_vld;
    logic [LANES-1:0]    head_we;
    logic                head_whilo;
    logic [CNT_W-1:0]    retire_inc;
    logic [CNT_W-1:0]    retire_cnt_q, retire_cnt_d;

    assign lane_wr = we_i & lane_vld_i;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic later_hit;
            // A later lane writing the same register in this bundle wins
            always_comb begin
                later_hit = 1'b0;
                for (int j = gi + 1; j < LANES; j++) begin
                    if (lane_wr[j] && (waddr_i[5*j +: 5] == waddr_i[5*gi +: 5])) later_hit = 1'b1;
                end
            end
            assign we_san[gi] = (lane_wr[gi] && (waddr_i[5*gi +: 5] != NOP_REG_ADDR) && !later_hit)
                                ? WRITE_ENABLE : WRITE_DISABLE;
            assign wdata_san[32*gi +: 32] = lane_vld_i[gi] ? wdata_i[32*gi +: 32] : ZERO_WORD;
        end
    endgenerate

    assign wr_bundle = {whilo_i, lo_i, hi_i, wdata_san, we_san, waddr_i, lane_vld_i, pc_i};

    assign in_ready  = ~fifo_full;
    assign out_valid = ~fifo_empty;
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    commit_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (wr_bundle),
        .rdata_o (rd_bundle),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {head_whilo, lo_o, hi_o, wdata_o, head_we, waddr_o, head_vld, pc_o} = rd_bundle;

    // Write strobes are gated so an empty buffer presents a bubble
    assign we_o    = head_we & {LANES{out_valid}};
    assign whilo_o = head_whilo & out_valid;

    always_comb begin
        retire_inc = '0;
        for (int k = 0; k < LANES; k++) retire_inc = retire_inc + CNT_W'(head_vld[k]);
    end

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (pop) retire_cnt_d = retire_cnt_q + retire_inc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) retire_cnt_q <= '0;
        else      retire_cnt_q <= retire_cnt_d;
    end

    assign retire_cnt_o = retire_cnt_q;

endmodule

// File: tb/tb_commit_buffer.sv
// Randomised and directed bench for commit_buffer against a queue-based bundle model.
module tb_commit_buffer;

    localparam int L  = 2;
    localparam int D  = 2;
    localparam int CW = 4;

    typedef struct packed {
        logic [31:0]        pc;
        logic [L-1:0]       vld;
        logic [L-1:0][4:0]  waddr;
        logic [L-1:0]       we;
        logic [L-1:0][31:0] wdata;
        logic [31:0]        hi;
        logic [31:0]        lo;
        logic               whilo;
    } bundle_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       pc_i;
    logic [L-1:0]      lane_vld_i;
    logic [5*L-1:0]    waddr_i;
    logic [L-1:0]      we_i;
    logic [32*L-1:0]   wdata_i;
    logic [31:0]       hi_i;
    logic [31:0]       lo_i;
    logic              whilo_i;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       pc_o;
    logic [5*L-1:0]    waddr_o;
    logic [L-1:0]      we_o;
    logic [32*L-1:0]   wdata_o;
    logic [31:0]       hi_o;
    logic [31:0]       lo_o;
    logic              whilo_o;
    logic [CW-1:0]     retire_cnt_o;

    bundle_t q[$];
    int      exp_ret;
    int      n_vec;
    int      n_err;

    always #5 clk = ~clk;

    commit_buffer #(.LANES(L), .DEPTH(D), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pc_i         (pc_i),
        .lane_vld_i   (lane_vld_i),
        .waddr_i      (waddr_i),
        .we_i         (we_i),
        .wdata_i      (wdata_i),
        .hi_i         (hi_i),
        .lo_i         (lo_i),
        .whilo_i      (whilo_i),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .pc_o         (pc_o),
        .waddr_o      (waddr_o),
        .we_o         (we_o),
        .wdata_o      (wdata_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .whilo_o      (whilo_o),
        .retire_cnt_o (retire_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected stored bundle: r0 and invalid lanes never write, later lane wins on same reg
    function automatic bundle_t sanit(input bundle_t b);
        bundle_t r;
        r = b;
        for (int k = 0; k < L; k++) begin
            r.we[k]    = 1'b0;
            r.wdata[k] = b.vld[k] ? b.wdata[k] : 32'h0;
            if (b.vld[k] && b.we[k] && b.waddr[k] != 5'd0) begin
                bit later = 1'b0;
                for (int j = k + 1; j < L; j++)
                    if (b.vld[j] && b.we[j] && b.waddr[j] == b.waddr[k]) later = 1'b1;
                r.we[k] = !later;
            end
        end
        return r;
    endfunction

    function automatic bundle_t mk(input logic [31:0] pc, input logic [1:0] vld, input logic [1:0] we,
                                   input logic [4:0] a0, input logic [4:0] a1,
                                   input logic [31:0] d0, input logic [31:0] d1);
        bundle_t b;
        b.pc = pc; b.vld = vld; b.we = we;
        b.waddr[0] = a0; b.waddr[1] = a1;
        b.wdata[0] = d0; b.wdata[1] = d1;
        b.hi = ~pc; b.lo = pc ^ 32'h5a5a_5a5a; b.whilo = pc[3];
        return b;
    endfunction

    function automatic bundle_t rnd();
        bundle_t b;
        b.pc    = $urandom & 32'hffff_fffc;
        b.vld   = L'($urandom);
        b.we    = L'($urandom);
        for (int k = 0; k < L; k++) begin
            b.waddr[k] = 5'($urandom_range(0, 3));
            b.wdata[k] = $urandom;
        end
        b.hi    = $urandom;
        b.lo    = $urandom;
        b.whilo = 1'($urandom);
        return b;
    endfunction

    task automatic check_outputs();
        bundle_t h;
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() != D));
        chk("retire_cnt", 64'(retire_cnt_o), 64'(exp_ret));
        if (q.size() == 0) begin
            chk("bubble_we", 64'(we_o), 64'(0));
            chk("bubble_whilo", 64'(whilo_o), 64'(0));
        end else begin
            h = q[0];
            chk("pc", 64'(pc_o), 64'(h.pc));
            chk("we", 64'(we_o), 64'(h.we));
            chk("whilo", 64'(whilo_o), 64'(h.whilo));
            chk("hi", 64'(hi_o), 64'(h.hi));
            chk("lo", 64'(lo_o), 64'(h.lo));
            for (int k = 0; k < L; k++) begin
                chk("wdata", 64'(wdata_o[32*k +: 32]), 64'(h.wdata[k]));
                if (h.vld[k]) chk("waddr", 64'(waddr_o[5*k +: 5]), 64'(h.waddr[k]));
            end
        end
    endtask

    // One clock: drive at negedge, check at negedge+1, update model at posedge
    task automatic cycle(input bundle_t b, input bit iv, input bit ordy, input bit fl, output bit acc);
        bit pop_m;
        in_valid   = iv;
        pc_i       = b.pc;
        lane_vld_i = b.vld;
        waddr_i    = b.waddr;
        we_i       = b.we;
        wdata_i    = b.wdata;
        hi_i       = b.hi;
        lo_i       = b.lo;
        whilo_i    = b.whilo;
        out_ready  = ordy;
        flush      = fl;
        #1;
        check_outputs();
        acc   = iv && (q.size() != D);
        pop_m = (q.size() != 0) && ordy;
        @(posedge clk);
        if (pop_m) begin
            exp_ret = (exp_ret + $countones(q[0].vld)) % (1 << CW);
            void'(q.pop_front());
        end
        if (fl) q.delete();
        else if (acc) q.push_back(sanit(b));
        @(negedge clk);
    endtask

    task automatic send(input bundle_t b, input bit ordy);
        bit acc;
        int n = 0;
        do begin
            cycle(b, 1'b1, ordy, 1'b0, acc);
            n++;
        end while (!acc && n < 20);
        if (!acc) chk("accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic idle(input int cycles, input bit ordy);
        bit acc;
        for (int i = 0; i < cycles; i++) cycle(rnd(), 1'b0, ordy, 1'b0, acc);
    endtask

    task automatic async_reset();
        #2 rst = 1'b0;
        #1;
        q.delete();
        exp_ret = 0;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_retire", 64'(retire_cnt_o), 64'(0));
        chk("rst_pc", 64'(pc_o), 64'(0));
        chk("rst_we", 64'(we_o), 64'(0));
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bit      acc;
        int      ret0;
        bundle_t b;
        n_vec = 0; n_err = 0; exp_ret = 0;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        pc_i = '0; lane_vld_i = '0; waddr_i = '0; we_i = '0; wdata_i = '0;
        hi_i = '0; lo_i = '0; whilo_i = 1'b0;
        #3;
        check_outputs();
        chk("init_pc", 64'(pc_o), 64'(0));
        chk("init_hi", 64'(hi_o), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Backpressure: third bundle held until space frees, heads in order
        send(mk(32'h100, 2'b11, 2'b00, 5'd1, 5'd2, 32'h1, 32'h2), 1'b0);
        send(mk(32'h108, 2'b11, 2'b00, 5'd1, 5'd2, 32'h3, 32'h4), 1'b0);
        b = mk(32'h110, 2'b11, 2'b00, 5'd1, 5'd2, 32'h5, 32'h6);
        cycle(b, 1'b1, 1'b0, 1'b0, acc);
        chk("held_full", 64'(acc), 64'(0));
        cycle(b, 1'b1, 1'b0, 1'b0, acc);
        chk("held_full", 64'(acc), 64'(0));
        send(b, 1'b1);
        idle(3, 1'b1);

        // Reset mid-stream with two bundles buffered
        send(rnd(), 1'b0);
        send(rnd(), 1'b0);
        async_reset();

        // Intra-bundle WAW: later lane wins
        send(mk(32'h200, 2'b11, 2'b11, 5'd5, 5'd5, 32'h1111, 32'h2222), 1'b0);
        #1;
        chk("waw_we", 64'(we_o), 64'(2'b10));
        chk("waw_wdata1", 64'(wdata_o[63:32]), 64'h2222);
        idle(1, 1'b1);

        // r0 write and invalid lane suppressed; only one instruction retires
        ret0 = exp_ret;
        send(mk(32'h300, 2'b01, 2'b11, 5'd0, 5'd7, 32'hdead, 32'hbeef), 1'b0);
        #1;
        chk("r0_we", 64'(we_o), 64'(2'b00));
        idle(1, 1'b1);
        chk("r0_retire", 64'(retire_cnt_o), 64'((ret0 + 1) % 16));

        // Flush with a simultaneous pop: head retires, incoming dropped
        send(mk(32'h400, 2'b11, 2'b11, 5'd3, 5'd4, 32'ha, 32'hb), 1'b0);
        send(mk(32'h408, 2'b11, 2'b11, 5'd3, 5'd4, 32'hc, 32'hd), 1'b0);
        ret0 = exp_ret;
        cycle(mk(32'h410, 2'b11, 2'b11, 5'd6, 5'd8, 32'he, 32'hf), 1'b1, 1'b1, 1'b1, acc);
        #1;
        chk("flush_empty", 64'(out_valid), 64'(0));
        chk("flush_we", 64'(we_o), 64'(0));
        chk("flush_retire", 64'(retire_cnt_o), 64'((ret0 + 2) % 16));
        idle(2, 1'b1);

        // Counter wrap: 17 instructions on a 4-bit counter
        async_reset();
        for (int i = 0; i < 8; i++) send(mk(32'h500 + 32'(8*i), 2'b11, 2'b00, 5'd1, 5'd2, 32'h0, 32'h0), 1'b1);
        send(mk(32'h600, 2'b01, 2'b00, 5'd1, 5'd2, 32'h0, 32'h0), 1'b1);
        idle(3, 1'b1);
        chk("cnt_wrap", 64'(retire_cnt_o), 64'(1));

        // Random traffic with occasional flushes
        for (int i = 0; i < 500; i++)
            cycle(rnd(), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 19) == 0), acc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
